// File: rtl/fp_round_norm.sv
// Floating-point round-and-normalize pipeline: operand register, rounding stage,
// leading-zero normalization into registered outputs, with a single global advance enable.
module fp_round_norm #(
   parameter int DATA_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              sign,
   input  logic [EXP_W-1:0]  exponent,
   input  logic [DATA_W+2:0] mantissa,
   input  logic [2:0]        rnd_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP_W-1:0]  exponent_rnd,
   output logic [DATA_W-1:0] mantissa_rnd,
   output logic [3:0]        flags
);

   localparam int SH_W = $clog2(DATA_W + 1);
   localparam int CW   = (SH_W > EXP_W + 1) ? SH_W : EXP_W + 1;

   function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                      input logic l, input logic g, input logic r, input logic s);
      logic x;
      x = g | r | s;
      case (mode)
         3'd1:    round_inc = 1'b0;
         3'd2:    round_inc = sgn & x;
         3'd3:    round_inc = ~sgn & x;
         3'd4:    round_inc = g;
         default: round_inc = g & (l | r | s);
      endcase
   endfunction

   // An all-zero significand reports DATA_W leading zeros.
   function automatic logic [SH_W-1:0] clz(input logic [DATA_W-1:0] v);
      clz = SH_W'(DATA_W);
      for (int i = 0; i < DATA_W; i++)
         if (v[i]) clz = SH_W'(DATA_W - 1 - i);
   endfunction

   logic              en;
   logic              vld_p0, vld_p1, vld_p2;
   logic              sign_p0;
   logic [EXP_W-1:0]  exp_p0;
   logic [DATA_W+2:0] mant_p0;
   logic [2:0]        mode_p0;
   logic [DATA_W-1:0] sig_p1;
   logic [EXP_W:0]    exp_p1;
   logic              inexact_p1;

   logic              inc_s1;
   logic [DATA_W:0]   sum_s1;
   logic [DATA_W-1:0] sig_s1;
   logic [EXP_W:0]    exp_s1;

   logic [SH_W-1:0]   lzc_s2;
   logic [CW-1:0]     lzc_w, exp_w, shift_w, adj_w;
   logic [DATA_W-1:0] mant_s2;
   logic [EXP_W-1:0]  exp_s2;
   logic [3:0]        flags_s2;

   assign en        = ~vld_p2 | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_p2;

   // Stage 1: round the registered operand; a carry-out renormalizes to 1.000...
   always_comb begin
      inc_s1 = round_inc(mode_p0, sign_p0, mant_p0[3], mant_p0[2], mant_p0[1], mant_p0[0]);
      sum_s1 = {1'b0, mant_p0[DATA_W+2:3]} + (DATA_W + 1)'(inc_s1);
      if (sum_s1[DATA_W]) begin
         sig_s1 = {1'b1, {(DATA_W - 1){1'b0}}};
         exp_s1 = {1'b0, exp_p0} + (EXP_W + 1)'(1);
      end else begin
         sig_s1 = sum_s1[DATA_W-1:0];
         exp_s1 = {1'b0, exp_p0};
      end
   end

   // Stage 2: normalize, clamping the shift at the exponent so small values go subnormal.
   always_comb begin
      lzc_s2   = clz(sig_p1);
      lzc_w    = CW'(lzc_s2);
      exp_w    = CW'(exp_p1);
      shift_w  = (lzc_w < exp_w) ? lzc_w : exp_w;
      adj_w    = exp_w - shift_w;
      mant_s2  = sig_p1 << shift_w;
      exp_s2   = adj_w[EXP_W-1:0];
      flags_s2 = {2'b00, inexact_p1, 1'b0};
      if (sig_p1 == '0) begin
         mant_s2     = '0;
         exp_s2      = '0;
         flags_s2[0] = 1'b1;
      end else if (adj_w >= CW'({EXP_W{1'b1}})) begin
         mant_s2     = '0;
         exp_s2      = '1;
         flags_s2[3] = 1'b1;
      end else if (lzc_w > exp_w) begin
         flags_s2[2] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         sign_p0    <= sign;
         exp_p0     <= exponent;
         mant_p0    <= mantissa;
         mode_p0    <= rnd_mode;
         sig_p1     <= sig_s1;
         exp_p1     <= exp_s1;
         inexact_p1 <= |mant_p0[2:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0       <= 1'b0;
         vld_p1       <= 1'b0;
         vld_p2       <= 1'b0;
         exponent_rnd <= '0;
         mantissa_rnd <= '0;
         flags        <= '0;
      end else if (en) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            exponent_rnd <= exp_s2;
            mantissa_rnd <= mant_s2;
            flags        <= flags_s2;
         end
      end
   end

endmodule

// File: tb/tb_fp_round_norm.sv
// Scoreboard bench for fp_round_norm: driver pushes expected results, monitor pops on output handshake.
module tb_fp_round_norm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        sign = 1'b0;
   logic [7:0]  exponent = '0;
   logic [26:0] mantissa = '0;
   logic [2:0]  rnd_mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  exponent_rnd;
   logic [23:0] mantissa_rnd;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   int cyc = 0;
   logic [35:0] exp_q[$];

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [26:0] m;
      logic [2:0]  md;
      logic [35:0] x;
   } vec_t;
   vec_t dir[$];

   fp_round_norm #(.DATA_W(24), .EXP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sign(sign), .exponent(exponent), .mantissa(mantissa), .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready), .exponent_rnd(exponent_rnd),
      .mantissa_rnd(mantissa_rnd), .flags(flags)
   );

   always #5 clk = ~clk;

   // Consumer: always ready, or the repeating 1,0,0 pattern.
   always @(posedge clk) begin
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: round by the mode rules, then shift left one bit at a time while the exponent allows.
   function automatic logic [35:0] model(input logic s, input logic [7:0] e, input logic [26:0] m,
                                         input logic [2:0] md);
      longint v;
      int     ee;
      bit     g, r, st, l, x, inc, uf;
      v  = longint'(m[26:3]);
      l  = m[3];
      g  = m[2];
      r  = m[1];
      st = m[0];
      x  = g | r | st;
      case (md)
         3'd1:    inc = 1'b0;
         3'd2:    inc = s & x;
         3'd3:    inc = !s & x;
         3'd4:    inc = g;
         default: inc = g & (l | r | st);
      endcase
      v  = v + longint'(inc);
      ee = int'(e);
      if (v == (longint'(1) << 24)) begin
         v  = longint'(1) << 23;
         ee = ee + 1;
      end
      if (v == 0) return {8'd0, 24'd0, 1'b0, 1'b0, x, 1'b1};
      while (v < (longint'(1) << 23) && ee > 0) begin
         v  = v * 2;
         ee = ee - 1;
      end
      uf = (v < (longint'(1) << 23));
      if (ee >= 255) return {8'hFF, 24'd0, 1'b1, 1'b0, x, 1'b0};
      return {8'(ee), 24'(v), 1'b0, uf, x, 1'b0};
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m,
                       input logic [2:0] md, input logic [35:0] x);
      bit acc;
      int n;
      sign = s; exponent = e; mantissa = m; rnd_mode = md; in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (acc) exp_q.push_back(x);
      else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      rnd_mode = 3'($urandom_range(0, 7));
      sign = ~sign;
   endtask

   task automatic send_rand();
      logic        s;
      logic [7:0]  e;
      logic [26:0] m;
      logic [2:0]  md;
      s  = 1'($urandom_range(0, 1));
      md = 3'($urandom_range(0, 7));
      m  = 27'($urandom() >> $urandom_range(0, 31));
      e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 254));
      if ($urandom_range(0, 15) == 0) begin
         m = 27'h7FFFFFF;
         e = 8'hFE;
      end
      send(s, e, m, md, model(s, e, m, md));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_result", 64'(out_valid), 64'(0));
            else begin
               check("result", 64'({exponent_rnd, mantissa_rnd, flags}), 64'(exp_q[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      dir.push_back('{1'b0, 8'h80, 27'h4000004, 3'd0, {8'h80, 24'h800000, 4'b0010}});
      dir.push_back('{1'b0, 8'h80, 27'h4000004, 3'd4, {8'h80, 24'h800001, 4'b0010}});
      dir.push_back('{1'b0, 8'h80, 27'h4000004, 3'd6, {8'h80, 24'h800000, 4'b0010}});
      dir.push_back('{1'b0, 8'h80, 27'h4000006, 3'd7, {8'h80, 24'h800001, 4'b0010}});
      dir.push_back('{1'b0, 8'h7F, 27'h7FFFFFC, 3'd0, {8'h80, 24'h800000, 4'b0010}});
      dir.push_back('{1'b0, 8'hFE, 27'h7FFFFFC, 3'd0, {8'hFF, 24'h000000, 4'b1010}});
      dir.push_back('{1'b1, 8'h80, 27'h4000007, 3'd2, {8'h80, 24'h800001, 4'b0010}});
      dir.push_back('{1'b1, 8'h80, 27'h4000007, 3'd3, {8'h80, 24'h800000, 4'b0010}});
      dir.push_back('{1'b1, 8'h80, 27'h4000007, 3'd1, {8'h80, 24'h800000, 4'b0010}});
      dir.push_back('{1'b0, 8'h40, 27'h0000008, 3'd1, {8'h29, 24'h800000, 4'b0000}});
      dir.push_back('{1'b0, 8'h05, 27'h0000008, 3'd1, {8'h00, 24'h000020, 4'b0100}});
      dir.push_back('{1'b0, 8'h17, 27'h0000008, 3'd1, {8'h00, 24'h800000, 4'b0000}});
      dir.push_back('{1'b0, 8'h40, 27'h0000000, 3'd1, {8'h00, 24'h000000, 4'b0001}});

      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_outputs", 64'({exponent_rnd, mantissa_rnd, flags}), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      sign = 1'b0; exponent = 8'h80; mantissa = 27'h4000004; rnd_mode = 3'd0; in_valid = 1'b1;
      @(negedge clk);
      check("first_edge_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      exp_q.push_back({8'h80, 24'h800000, 4'b0010});
      in_valid = 1'b0; rnd_mode = 3'd4; sign = 1'b1;
      @(negedge clk);
      check("latency_k0", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("latency_k1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("latency_k2", 64'(out_valid), 64'(1));
      @(posedge clk);
      #1;

      foreach (dir[i]) send(dir[i].s, dir[i].e, dir[i].m, dir[i].md, dir[i].x);
      drain();

      repeat (150) send_rand();
      drain();

      rdy_mode = 1;
      for (int i = 0; i < 48; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         send_rand();
      end
      drain();

      repeat (4) send_rand();
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_outputs", 64'({exponent_rnd, mantissa_rnd, flags}), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_edge1", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("post_rst_edge2", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;

      rdy_mode = 0;
      repeat (20) send_rand();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_round_norm.md
FP_ROUND_NORM -- requirements
Module: fp_round_norm

Interface
REQ-001 Parameter DATA_W, default 24, significand width including the explicit leading bit.
REQ-002 Parameter EXP_W, default 8, biased exponent width.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, operand present.
REQ-006 Port in_ready, output, 1, operand accepted on a clk edge where in_valid & in_ready.
REQ-007 Port sign, input, 1, operand sign; used only for the directed rounding modes.
REQ-008 Port exponent, input, EXP_W, biased exponent; the value 2^EXP_W-1 is not a legal input.
REQ-009 Port mantissa, input, DATA_W+3: bits [DATA_W+2:3] significand, [2] G, [1] R, [0] S.
REQ-010 Port rnd_mode, input, 3: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; codes 5-7 behave as RNE.
REQ-011 Port out_valid, output, 1, result present.
REQ-012 Port out_ready, input, 1, consumer accepts on a clk edge where out_valid & out_ready.
REQ-013 Port exponent_rnd, output, EXP_W, result exponent.
REQ-014 Port mantissa_rnd, output, DATA_W, result significand.
REQ-015 Port flags, output, 4: [3] overflow, [2] underflow, [1] inexact, [0] zero.

Function
REQ-016 Pipeline shall be two register stages with a global advance enable en = ~out_valid | out_ready; in_ready shall equal en.
REQ-017 Latency: an operand accepted at edge k shall appear with out_valid=1 after edge k+2, provided en stays 1.
REQ-018 While out_valid=1 and out_ready=0, all outputs and both stages shall hold; no operand shall be lost or duplicated.
REQ-019 Back-to-back operation: one result per cycle whenever in_valid=1 and out_ready=1.
REQ-020 Stage 1 round increment, with L=mantissa[3] and X=G|R|S: RNE G&(L|R|S); RTZ 0; RDN sign&X; RUP ~sign&X; RMM G.
REQ-021 Stage 1 shall compute the significand plus increment in DATA_W+1 bits; carry-out shall set the significand to 1 followed by DATA_W-1 zeros and add 1 to the exponent, computed in EXP_W+1 bits.
REQ-022 inexact shall equal G|R|S of the accepted operand, independent of rnd_mode.
REQ-023 Stage 2 shall count leading zeros of the rounded significand using the existing clz counter, with shift = min(lzc, exponent).
REQ-024 Stage 2 shall set mantissa_rnd = significand << shift and exponent_rnd = exponent - shift.
REQ-025 underflow shall be 1 when lzc > exponent and the significand is nonzero; the result is then a subnormal with exponent_rnd = 0.
REQ-026 Zero significand after rounding: mantissa_rnd=0, exponent_rnd=0, zero=1, underflow=0.
REQ-027 Overflow: if the adjusted exponent is >= 2^EXP_W-1, set overflow=1, exponent_rnd=all ones and mantissa_rnd=0 (infinity).
REQ-028 rnd_mode and sign shall be registered with the operand; changing them mid-flight shall not affect in-flight results.

Reset
REQ-029 While rst_n=0: both stage valid bits, out_valid, exponent_rnd, mantissa_rnd and flags shall be 0, and in_ready shall be 1.
REQ-030 Reset asserted mid-operation shall discard all in-flight operands asynchronously; no result shall be emitted for them after release.
REQ-031 The first operand may be accepted on the first rising edge after rst_n deasserts.

Verification (DATA_W=24, EXP_W=8)
REQ-032 Tie-even: mantissa=27'h4000004, exp=8'h80, RNE -> mantissa_rnd=24'h800000, exp 8'h80, flags=4'b0010; same with RMM -> 24'h800001.
REQ-033 Carry: mantissa=27'h7FFFFFC, exp=8'h7F, RNE -> 24'h800000, exp 8'h80, inexact=1; with exp=8'hFE -> exp 8'hFF, mantissa 0, flags=4'b1010.
REQ-034 Directed: mantissa=27'h4000007, sign=1: RDN -> 24'h800001; RUP -> 24'h800000; RTZ -> 24'h800000; all with inexact=1.
REQ-035 Normalize: mantissa=27'h0000008, exp=8'h40, RTZ -> 24'h800000, exp 8'h29; exp=8'h05 -> 24'h000020, exp 0, underflow=1; mantissa=0 -> zero=1.
REQ-036 Backpressure: stream 8 operands with out_ready toggling 1,0,0,1,... and random in_valid gaps -> results in order, none lost or duplicated, outputs stable while stalled, out_valid=0 two edges after rst_n pulse mid-stream.
